// File: rtl/gf2m_pkg.sv
// Shared GF(2^67) definitions: field degree, pentanomial taps,
// multiplier-arbiter FSM encoding and default watchdog length.
package gf2m_pkg;

  localparam int GF_M = 67;

  // x^67 + x^5 + x^2 + x + 1
  localparam int K3 = 5;
  localparam int K2 = 2;
  localparam int K1 = 1;

  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit at or after ptr, wrapping.
// Ports: req/ptr in; one-hot win, index w, any out (combinational).
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   w,
  output logic            any
);

  int              idx;
  logic [NREQ-1:0] sel;

  always_comb begin
    win = '0;
    w   = '0;
    any = 1'b0;
    idx = 0;
    sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      sel = NREQ'(1) << idx;
      if (!any && ((req & sel) != '0)) begin
        any = 1'b1;
        win = sel;
        w   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/gf2m_mul_arbiter.sv
// Round-robin sharing of one start/done GF(2^m) multiplier among NREQ
// requesters: req/operands in, gnt/rsp_valid/rsp_data/rsp_err out, mul_* to core.
module gf2m_mul_arbiter
  import gf2m_pkg::*;
#(
  parameter int M       = GF_M,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int IW      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*M-1:0] req_op_a,
  input  logic [NREQ*M-1:0] req_op_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [M-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              mul_start,
  output logic [M-1:0]      mul_op_a,
  output logic [M-1:0]      mul_op_b,
  input  logic              mul_done,
  input  logic [M-1:0]      mul_op_c
);

  localparam int WW = $clog2(TIMEOUT + 1);

  arb_state_t      state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   w_q;
  logic [WW-1:0]   wd;

  logic [NREQ-1:0] win;
  logic [IW-1:0]   w;
  logic            any;
  logic [M-1:0]    sel_a;
  logic [M-1:0]    sel_b;
  logic [IW-1:0]   ptr_nxt;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .w   (w),
    .any (any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        sel_a = req_op_a[i*M +: M];
        sel_b = req_op_b[i*M +: M];
      end
    end
  end

  assign ptr_nxt = (w == IW'(NREQ - 1)) ? '0 : w + 1'b1;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      w_q       <= '0;
      wd        <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_op_a  <= '0;
      mul_op_b  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any) begin
            w_q       <= w;
            mul_op_a  <= sel_a;
            mul_op_b  <= sel_b;
            ptr       <= ptr_nxt;
            gnt       <= win;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          gnt       <= '0;
          mul_start <= 1'b0;
          wd        <= '0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          wd <= wd + 1'b1;
          // done beats a same-cycle watchdog expiry
          if (mul_done) begin
            rsp_data  <= mul_op_c;
            rsp_err   <= 1'b0;
            rsp_valid <= NREQ'(1) << w_q;
            state     <= ST_RESP;
          end else if (wd == WW'(TIMEOUT - 1)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= NREQ'(1) << w_q;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_valid <= '0;
          rsp_err   <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_mul_arbiter.sv
// Bench for gf2m_mul_arbiter: multiplier stub, transaction-level model
// checked every cycle, plus directed vectors with literal expectations.
module tb_gf2m_mul_arbiter;
  import gf2m_pkg::*;

  localparam int M       = 67;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int IW      = 2;
  localparam int DELAY   = 6;
  localparam logic [M-1:0] GARB = 67'h5A5A5A5A5A5A5A5A5;

  logic              clk;
  logic              rst_b;
  logic [NREQ-1:0]   req;
  logic [NREQ*M-1:0] req_op_a;
  logic [NREQ*M-1:0] req_op_b;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [M-1:0]      rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              mul_start;
  logic [M-1:0]      mul_op_a;
  logic [M-1:0]      mul_op_b;
  logic              mul_done;
  logic [M-1:0]      mul_op_c;

  gf2m_mul_arbiter #(
    .M       (M),
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT),
    .IW      (IW)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .req       (req),
    .req_op_a  (req_op_a),
    .req_op_b  (req_op_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .mul_start (mul_start),
    .mul_op_a  (mul_op_a),
    .mul_op_b  (mul_op_b),
    .mul_done  (mul_done),
    .mul_op_c  (mul_op_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h want=%h", nm, got, exp);
  endtask

  function automatic logic [M-1:0] gfmul(input logic [M-1:0] a,
                                         input logic [M-1:0] b);
    logic [2*M-1:0] p;
    logic [2*M-1:0] poly;
    p = '0;
    poly = '0;
    poly[M] = 1'b1;
    poly[K3] = 1'b1;
    poly[K2] = 1'b1;
    poly[K1] = 1'b1;
    poly[0] = 1'b1;
    for (int i = 0; i < M; i++)
      if (b[i]) p = p ^ ({{M{1'b0}}, a} << i);
    for (int i = 2*M-1; i >= M; i--)
      if (p[i]) p = p ^ (poly << (i - M));
    return p[M-1:0];
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  // multiplier stub
  bit stub_stuck = 0;
  int force_cyc  = -1;
  int done_at    = -1;

  always @(negedge clk)
    if (mul_start === 1'b1) done_at = cyc + DELAY;

  always @(posedge clk) begin
    #1;
    if ((!stub_stuck && cyc == done_at) || cyc == force_cyc) begin
      mul_done = 1'b1;
      mul_op_c = gfmul(mul_op_a, mul_op_b);
    end else begin
      mul_done = 1'b0;
      mul_op_c = GARB;
    end
  end

  // transaction-level model, compared every cycle
  bit           mv = 0;
  bit           in_txn = 0;
  int           ts = 0;
  int           tr = -1;
  bit           merr = 0;
  int           mptr = 0;
  int           mw = 0;
  logic [M-1:0] ea = '0, eb = '0, edata = '0;
  logic [M-1:0] hd = '0, oa = '0, ob = '0;

  always @(negedge clk) begin : cmp
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] ev;
    logic            ee;
    logic            ebusy;
    if (mv) begin
      if (in_txn && cyc == tr) hd = edata;
      if (in_txn && cyc == ts) begin
        oa = ea;
        ob = eb;
      end
      eg    = (in_txn && cyc == ts) ? oh(mw) : '0;
      ev    = (in_txn && cyc == tr) ? oh(mw) : '0;
      ee    = in_txn && cyc == tr && merr;
      ebusy = in_txn && cyc >= ts && (tr < 0 || cyc <= tr);
      check("cycle_model",
        {gnt, rsp_valid, mul_start, busy, rsp_err, rsp_data, mul_op_a, mul_op_b},
        {eg, ev, (eg != '0), ebusy, ee, hd, oa, ob});
    end
    if (rst_b) begin
      in_txn = 0;
      mptr = 0;
      hd = '0;
      oa = '0;
      ob = '0;
      mv = 1;
    end else if (mv) begin
      if (in_txn) begin
        if (tr < 0 && cyc > ts) begin
          if (mul_done) begin
            tr = cyc + 1;
            merr = 0;
            edata = gfmul(ea, eb);
          end else if (cyc == ts + TIMEOUT) begin
            tr = cyc + 1;
            merr = 1;
            edata = '0;
          end
        end else if (cyc == tr) begin
          in_txn = 0;
        end
      end else if (req != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          int id;
          id = (mptr + k) % NREQ;
          if (req[id]) begin
            mw = id;
            break;
          end
        end
        ea = req_op_a[mw*M +: M];
        eb = req_op_b[mw*M +: M];
        mptr = (mw + 1) % NREQ;
        in_txn = 1;
        ts = cyc + 1;
        tr = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [M-1:0] a,
                        input logic [M-1:0] b);
    req_op_a[i*M +: M] = a;
    req_op_b[i*M +: M] = b;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1;
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic txn(input int i, input logic [M-1:0] a,
                     input logic [M-1:0] b, input logic [M-1:0] xd,
                     input int lat, input bit xerr, input int force_off);
    int t;
    int got_c;
    bit seen;
    tick();
    set_op(i, a, b);
    req = oh(i);
    t = cyc;
    if (force_off >= 0) force_cyc = t + force_off;
    @(negedge clk);
    @(negedge clk);
    check("gnt", gnt, oh(i));
    check("mul_start", mul_start, 1'b1);
    tick();
    req = '0;
    seen = 0;
    got_c = 0;
    for (int k = 0; k < TIMEOUT + 20 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        seen = 1;
        got_c = cyc;
      end
    end
    if (!seen) check("rsp_timeout", 0, 1);
    else begin
      check("rsp_lat", got_c - t, lat);
      check("rsp_valid", rsp_valid, oh(i));
      check("rsp_data", rsp_data, xd);
      check("rsp_err", rsp_err, xerr);
    end
  endtask

  int gq[$];
  int gc[$];

  task automatic run_held(input logic [NREQ-1:0] r, input int n);
    gq.delete();
    gc.delete();
    tick();
    req = r;
    for (int k = 0; k < n * 12 + 10 && gq.size() < n; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        for (int j = 0; j < NREQ; j++)
          if (gnt[j]) gq.push_back(j);
        gc.push_back(cyc);
      end
    end
    if (gq.size() < n) check("held_grant_timeout", gq.size(), n);
    tick();
    req = '0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin : stim
    logic [M-1:0] hi;
    int t;
    bit seen;
    rst_b = 1'b1;
    req = '0;
    req_op_a = '0;
    req_op_b = '0;
    mul_done = 1'b0;
    mul_op_c = GARB;
    repeat (3) tick();
    rst_b = 1'b0;
    @(negedge clk);
    check("reset_state",
      {gnt, rsp_valid, mul_start, busy, rsp_err, rsp_data, mul_op_a, mul_op_b}, '0);

    // single request, 2*3 = 6, response 8 cycles after req
    txn(2, 67'd2, 67'd3, 67'd6, 8, 1'b0, -1);

    // ptr now 3: 0011 wraps to 0, then 1
    set_op(0, 67'h11, 67'h3);
    set_op(1, 67'h1234, 67'h100);
    run_held(4'b0011, 2);
    if (gq.size() == 2) begin
      check("wrap_first", gq[0], 0);
      check("wrap_second", gq[1], 1);
      check("wrap_interval", gc[1] - gc[0], 9);
    end

    // reduction: x^66 * x = x^5+x^2+x+1
    hi = '0;
    hi[M-1] = 1'b1;
    txn(3, hi, 67'd2, 67'h27, 8, 1'b0, -1);

    // all requesters held: strict rotation, 9 cycles apart
    for (int i = 0; i < NREQ; i++)
      set_op(i, 67'(i + 5), 67'h1 << (60 + i));
    run_held(4'b1111, 8);
    if (gq.size() == 8) begin
      for (int k = 0; k < 8; k++) check("rr_order", gq[k], k % 4);
      check("rr_span", gc[7] - gc[0], 63);
    end

    // watchdog: done never comes
    stub_stuck = 1;
    txn(1, 67'd9, 67'd9, 67'd0, TIMEOUT + 2, 1'b1, -1);
    stub_stuck = 0;

    // next request served normally: (x^2+1)(x^2+x+1) = 0x1b
    txn(2, 67'd5, 67'd7, 67'h1b, 8, 1'b0, -1);

    // done in the expiry cycle wins
    stub_stuck = 1;
    txn(0, 67'd2, 67'd3, 67'd6, TIMEOUT + 2, 1'b0, TIMEOUT + 1);
    stub_stuck = 0;
    force_cyc = -1;

    // reset in the middle of WAIT
    tick();
    set_op(1, 67'd3, 67'd3);
    req = oh(1);
    t = cyc;
    tick();
    req = '0;
    tick();
    tick();
    tick();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    @(negedge clk);
    check("reset_mid_wait",
      {gnt, rsp_valid, mul_start, busy, rsp_err, rsp_data, mul_op_a, mul_op_b}, '0);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) seen = 1;
    end
    check("late_done_ignored", seen, 0);
    check("late_done_window", cyc - t > DELAY + 2, 1);

    // ptr back at 0: 1001 goes to 0, not 3
    tick();
    req = 4'b1001;
    @(negedge clk);
    @(negedge clk);
    check("ptr_after_reset", gnt, 4'b0001);
    tick();
    req = '0;
    wait_idle();

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
